// File: rtl/playseq_fluxo_dados.sv
// playseq_fluxo_dados: PlaySeq datapath (counters, sequence store, timers, LED mux).
// Define PLAYSEQ_TIMEOUT_EN to build the play timer; otherwise timeout is tied low.
module playseq_fluxo_dados #(
    parameter int TIMEOUT_M = 5000,
    parameter int LEDS_M    = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       zeraE,
    input  logic       contaE,
    input  logic       carregaS,
    input  logic       zeraS,
    input  logic       contaS,
    input  logic       zeraR,
    input  logic       registraR,
    input  logic       zeraJ,
    input  logic       contaJ,
    input  logic       zeraT,
    input  logic       contaT,
    input  logic       zeraT_leds,
    input  logic       contaT_leds,
    input  logic       controla_leds,
    input  logic       fase_preview,
    input  logic [1:0] nivel_uc,
    input  logic [1:0] memoria_uc,
    input  logic       ram_escreve,
    output logic       fimE,
    output logic       igualE,
    output logic       igualS,
    output logic       menorS,
    output logic       pare,
    output logic       tem_jogada,
    output logic       timeout,
    output logic       timeoutL,
    output logic       vai_escrever,
    output logic [3:0] leds,
    output logic [3:0] db_contagem,
    output logic [3:0] db_limite,
    output logic [3:0] db_jogada,
    output logic [3:0] db_memoria,
    output logic [3:0] db_jogadas
);
    localparam int TW = $clog2(TIMEOUT_M);
    localparam int LW = $clog2(LEDS_M);

    logic [3:0] e_q, e_d, s_q, s_d, r_q, r_d, j_q, j_d;
    logic [3:0] limite, mem;
    logic [3:0] ram_q [16];
    logic       press_q;
    logic [LW-1:0] tl_q, tl_d;

    always_comb begin
        limite = nivel_uc[1] ? 4'd15 : 4'd7;
        e_d = zeraE ? 4'd0 : contaE ? e_q + 4'd1 : e_q;
        s_d = zeraS ? 4'd0 : carregaS ? (nivel_uc[0] ? limite : 4'd0) :
              (contaS && s_q < limite) ? s_q + 4'd1 : s_q;
        r_d = zeraR ? 4'd0 : registraR ? botoes : r_q;
        j_d = zeraJ ? 4'd0 : contaJ ? j_q + 4'd1 : j_q;
        tl_d = zeraT_leds ? '0 : (contaT_leds && tl_q != LW'(LEDS_M - 1)) ? tl_q + LW'(1) : tl_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_q     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            j_q     <= '0;
            tl_q    <= '0;
            press_q <= 1'b0;
        end else begin
            e_q     <= e_d;
            s_q     <= s_d;
            r_q     <= r_d;
            j_q     <= j_d;
            tl_q    <= tl_d;
            press_q <= |botoes;
        end
    end

    // User bank: not reset, so a recorded sequence survives a game restart.
    always_ff @(posedge clock) begin
        if (ram_escreve) ram_q[e_q] <= r_q;
    end

    always_comb begin
        mem = memoria_uc == 2'b00 ? 4'b0001 << e_q[1:0] :
              memoria_uc == 2'b01 ? 4'b1000 >> e_q[1:0] :
              memoria_uc == 2'b10 ? (e_q[1:0] == 2'd0 ? 4'b0001 : 4'b1000 >> (e_q[1:0] - 2'd1)) :
              ram_q[e_q];
    end

`ifdef PLAYSEQ_TIMEOUT_EN
    logic [TW-1:0] t_q, t_d;
    assign t_d = zeraT ? '0 : (contaT && t_q != TW'(TIMEOUT_M - 1)) ? t_q + TW'(1) : t_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) t_q <= '0;
        else       t_q <= t_d;
    end
    assign timeout = t_q == TW'(TIMEOUT_M - 1);
`else
    logic unused_t;
    assign unused_t = zeraT ^ contaT ^ (TW == 0);
    assign timeout  = 1'b0;
`endif

    assign timeoutL     = tl_q == LW'(LEDS_M - 1);
    assign fimE         = e_q == limite;
    assign igualE       = r_q == mem;
    assign igualS       = e_q == s_q;
    assign menorS       = s_q < e_q;
    assign pare         = igualS;
    assign tem_jogada   = |botoes & ~press_q;
    assign vai_escrever = memoria_uc == 2'b11;
    assign leds         = controla_leds ? mem : fase_preview ? 4'b0000 : botoes;
    assign db_contagem  = e_q;
    assign db_limite    = s_q;
    assign db_jogada    = r_q;
    assign db_memoria   = mem;
    assign db_jogadas   = j_q;
endmodule

// File: tb/tb_playseq_fluxo_dados.sv
// tb_playseq_fluxo_dados: directed self-checking bench for the PlaySeq datapath.
module tb_playseq_fluxo_dados;
`ifdef PLAYSEQ_TIMEOUT_EN
    localparam logic TEN = 1'b1;
`else
    localparam logic TEN = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    logic [3:0] botoes = '0;
    logic zeraE = 0, contaE = 0, carregaS = 0, zeraS = 0, contaS = 0, zeraR = 0, registraR = 0;
    logic zeraJ = 0, contaJ = 0, zeraT = 0, contaT = 0, zeraT_leds = 0, contaT_leds = 0;
    logic controla_leds = 0, fase_preview = 0, ram_escreve = 0;
    logic [1:0] nivel_uc = '0, memoria_uc = '0;
    logic fimE, igualE, igualS, menorS, pare, tem_jogada, timeout, timeoutL, vai_escrever;
    logic [3:0] leds, db_contagem, db_limite, db_jogada, db_memoria, db_jogadas;
    int checks = 0, errors = 0, pulses;

    playseq_fluxo_dados #(.TIMEOUT_M(4), .LEDS_M(4)) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .zeraE(zeraE), .contaE(contaE),
        .carregaS(carregaS), .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR), .registraR(registraR),
        .zeraJ(zeraJ), .contaJ(contaJ), .zeraT(zeraT), .contaT(contaT), .zeraT_leds(zeraT_leds),
        .contaT_leds(contaT_leds), .controla_leds(controla_leds), .fase_preview(fase_preview),
        .nivel_uc(nivel_uc), .memoria_uc(memoria_uc), .ram_escreve(ram_escreve),
        .fimE(fimE), .igualE(igualE), .igualS(igualS), .menorS(menorS), .pare(pare),
        .tem_jogada(tem_jogada), .timeout(timeout), .timeoutL(timeoutL), .vai_escrever(vai_escrever),
        .leds(leds), .db_contagem(db_contagem), .db_limite(db_limite), .db_jogada(db_jogada),
        .db_memoria(db_memoria), .db_jogadas(db_jogadas)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    initial begin
        #12 reset = 1'b0;
        chk("rst_E", db_contagem, 4'd0);
        chk("rst_S", db_limite, 4'd0);
        chk("rst_R", db_jogada, 4'd0);
        chk("rst_J", db_jogadas, 4'd0);
        chk1("rst_igualS", igualS, 1'b1);
        chk1("rst_fimE", fimE, 1'b0);
        chk1("rst_menorS", menorS, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_timeoutL", timeoutL, 1'b0);
        chk("rst_leds", leds, 4'd0);
        // reset mid-count
        step();
        contaE = 1; contaT = 1;
        repeat (3) step();
        contaT = 0;
        repeat (2) step();
        contaE = 0;
        chk("E5", db_contagem, 4'd5);
        chk1("t3_timeout", timeout, TEN);
        #2 reset = 1'b1;
        #1;
        chk("async_E", db_contagem, 4'd0);
        chk1("async_timeout", timeout, 1'b0);
        chk1("async_fimE", fimE, 1'b0);
        chk1("async_tem", tem_jogada, 1'b0);
        chk1("async_igualS", igualS, 1'b1);
        reset = 1'b0;
        // play timer
        step();
        contaT = 1;
        step(); step();
        chk1("t2_timeout", timeout, 1'b0);
        step();
        chk1("t3b_timeout", timeout, TEN);
        step(); step();
        chk1("t_sat_timeout", timeout, TEN);
        zeraT = 1;
        step();
        zeraT = 0; contaT = 0;
        chk1("t_clr_timeout", timeout, 1'b0);
        // LED timer
        contaT_leds = 1;
        step(); step();
        chk1("l2_timeoutL", timeoutL, 1'b0);
        step();
        chk1("l3_timeoutL", timeoutL, 1'b1);
        step();
        chk1("l_sat_timeoutL", timeoutL, 1'b1);
        zeraT_leds = 1;
        step();
        zeraT_leds = 0; contaT_leds = 0;
        chk1("l_clr_timeoutL", timeoutL, 1'b0);
        // counter E, level 16
        nivel_uc = 2'b10; carregaS = 1;
        step();
        carregaS = 0;
        chk("S_load0", db_limite, 4'd0);
        contaE = 1;
        repeat (14) step();
        chk("E14", db_contagem, 4'd14);
        chk1("E14_fimE", fimE, 1'b0);
        chk1("E14_menorS", menorS, 1'b1);
        step();
        chk("E15", db_contagem, 4'd15);
        chk1("E15_fimE", fimE, 1'b1);
        step();
        chk("E_wrap", db_contagem, 4'd0);
        chk1("E_wrap_fimE", fimE, 1'b0);
        repeat (3) step();
        zeraE = 1;
        step();
        zeraE = 0; contaE = 0;
        chk("E_clr_prio", db_contagem, 4'd0);
        // counter S
        nivel_uc = 2'b11; carregaS = 1;
        step();
        carregaS = 0;
        chk("S_loadlim", db_limite, 4'd15);
        chk1("S_igualS", igualS, 1'b0);
        chk1("S_pare", pare, 1'b0);
        contaS = 1;
        step();
        contaS = 0;
        chk("S_sat15", db_limite, 4'd15);
        zeraS = 1; carregaS = 1;
        step();
        zeraS = 0; carregaS = 0;
        chk("S_clr_prio", db_limite, 4'd0);
        nivel_uc = 2'b00; contaS = 1;
        repeat (9) step();
        chk("S_sat7", db_limite, 4'd7);
        carregaS = 1;
        step();
        carregaS = 0; contaS = 0;
        chk("S_load_prio", db_limite, 4'd0);
        // ROM banks and play register
        contaE = 1;
        step(); step();
        contaE = 0;
        memoria_uc = 2'b01; #1;
        chk("b01_e2", db_memoria, 4'd2);
        botoes = 4'b0010; registraR = 1;
        step();
        registraR = 0;
        chk("R_load", db_jogada, 4'd2);
        chk1("igualE_hit", igualE, 1'b1);
        chk("leds_botoes", leds, 4'b0010);
        controla_leds = 1; #1;
        chk("leds_mem", leds, 4'd2);
        memoria_uc = 2'b00; #1;
        chk("b00_e2", db_memoria, 4'd4);
        chk("leds_b00", leds, 4'd4);
        memoria_uc = 2'b10; #1;
        chk("b10_e2", db_memoria, 4'd4);
        controla_leds = 0; fase_preview = 1; #1;
        chk("leds_preview", leds, 4'd0);
        fase_preview = 0; memoria_uc = 2'b01; botoes = 4'b0100; registraR = 1;
        step();
        registraR = 0;
        chk("R_load2", db_jogada, 4'd4);
        chk1("igualE_miss", igualE, 1'b0);
        contaE = 1;
        step();
        contaE = 0;
        memoria_uc = 2'b10; #1;
        chk("b10_e3", db_memoria, 4'd2);
        memoria_uc = 2'b00; #1;
        chk("b00_e3", db_memoria, 4'd8);
        memoria_uc = 2'b01; #1;
        chk("b01_e3", db_memoria, 4'd1);
        // RAM write at E=3
        memoria_uc = 2'b11; #1;
        chk1("vai_escrever", vai_escrever, 1'b1);
        botoes = 4'b1000; registraR = 1;
        step();
        registraR = 0; ram_escreve = 1;
        step();
        ram_escreve = 0;
        chk("ram_read", db_memoria, 4'd8);
        chk1("ram_igualE", igualE, 1'b1);
        chk1("vai_escrever2", vai_escrever, 1'b1);
        zeraR = 1;
        step();
        zeraR = 0;
        chk("R_clr", db_jogada, 4'd0);
        // edge detector
        botoes = 4'b0000;
        step(); step();
        botoes = 4'b0001;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (tem_jogada) pulses++;
            step();
        end
        chk("pulse_hold", pulses[3:0], 4'd1);
        botoes = 4'b0000;
        step();
        botoes = 4'b0001;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (tem_jogada) pulses++;
            step();
        end
        chk("pulse_again", pulses[3:0], 4'd1);
        botoes = 4'b0000;
        // counter J
        contaJ = 1;
        repeat (3) step();
        chk("J3", db_jogadas, 4'd3);
        zeraJ = 1;
        step();
        zeraJ = 0;
        chk("J_clr_prio", db_jogadas, 4'd0);
        repeat (17) step();
        contaJ = 0;
        chk("J_wrap", db_jogadas, 4'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
